// File: rtl/vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch
//   Frame-buffer reader for the VGA output stage. A classic Wishbone master
//   reads 32-bit pixel words sequentially from memory into a sync FIFO. The
//   timing stage pops one pixel per active pixel clock and gets 24-bit RGB
//   one cycle later. At each frame start the fetch re-aligns itself to pixel
//   (0,0) if the frame was consumed short, long, or underflowed.
//
// Optional feature macro: VGA_FETCH_STATS_EN
//   Adds underflow_cnt (16-bit, saturating count of empty pops) and
//   resync_cnt (8-bit, saturating count of flushes).
//
// Ports
//   CLK, RST      pixel clock, synchronous active-high reset
//   wbm_cyc/stb   Wishbone cycle/strobe (identical)
//   wbm_we        always 0 (read-only master)
//   wbm_sel       always 4'hF
//   wbm_adr       byte address, steps by 4, wraps at end of frame
//   wbm_dat_i     read data, [23:0] = {R,G,B}, [31:24] ignored
//   wbm_ack       Wishbone acknowledge
//   frame_start   1-cycle pulse in vertical blanking
//   pix_req       active-pixel pop strobe
//   pix_rgb       registered pixel, 0 when not popping or popping empty
//   underflow     sticky flag: pop attempted on empty FIFO
// ----------------------------------------------------------------------------
module vga_pixel_fetch #(
    parameter int unsigned HDISP      = 640,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned FIFO_DEPTH = 256
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        wbm_cyc,
    output logic        wbm_stb,
    output logic        wbm_we,
    output logic [3:0]  wbm_sel,
    output logic [31:0] wbm_adr,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack,
    input  logic        frame_start,
    input  logic        pix_req,
    output logic [23:0] pix_rgb,
    output logic        underflow
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0] underflow_cnt,
    output logic [7:0]  resync_cnt
`endif
);

    localparam int unsigned   TOTAL     = HDISP * VDISP;
    localparam int unsigned   PCW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0]   LAST_ADDR = BASE_ADDR + 32'(4 * (TOTAL - 1));
    localparam logic [PCW-1:0] PCNT_MAX = PCW'(TOTAL - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t          r_state;
    logic            r_cyc;
    logic [31:0]     r_adr;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [PCW-1:0]  r_pcnt;
    logic            r_ferr;
    logic            r_pend;
    logic [23:0]     r_rgb;
    logic            r_uflow;

    logic            w_empty;
    logic            w_pop;
    logic            w_empty_pop;
    logic            w_push;
    logic            w_flush;
    logic [PCW-1:0]  w_pcnt_nxt;
    logic            w_ferr_nxt;
    logic            w_unused_dat;

    assign w_unused_dat = ^wbm_dat_i[31:24];

    assign w_empty     = (r_count == '0);
    assign w_pop       = pix_req && !w_empty;
    assign w_empty_pop = pix_req && w_empty;
    // A word acked while a resync is pending belongs to the old frame.
    assign w_push      = (r_state == S_READ) && wbm_ack && !r_pend;
    assign w_flush     = (r_state == S_IDLE) && r_pend;

    // Alignment at frame_start is judged on the post-pop counter/error state.
    assign w_pcnt_nxt = !pix_req ? r_pcnt :
                        (r_pcnt == PCNT_MAX) ? '0 : r_pcnt + 1'b1;
    assign w_ferr_nxt = r_ferr | w_empty_pop;

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wptr] <= wbm_dat_i[23:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_adr   <= BASE_ADDR;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_pcnt  <= '0;
            r_ferr  <= 1'b0;
            r_pend  <= 1'b0;
            r_rgb   <= '0;
            r_uflow <= 1'b0;
        end else begin
            r_rgb  <= w_pop ? r_mem[r_rptr] : '0;
            r_pcnt <= w_pcnt_nxt;
            r_ferr <= w_ferr_nxt;
            if (w_empty_pop)
                r_uflow <= 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

            case (r_state)
                S_IDLE: begin
                    // Issuing only below full guarantees the ack finds room.
                    if (!r_pend && (r_count != FULL_CNT)) begin
                        r_state <= S_READ;
                        r_cyc   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (wbm_ack) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        if (!r_pend)
                            r_adr <= (r_adr == LAST_ADDR) ? BASE_ADDR : r_adr + 32'd4;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase

            // Flush overrides the normal pointer/count/counter updates above.
            if (w_flush) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_adr   <= BASE_ADDR;
                r_pcnt  <= '0;
                r_ferr  <= 1'b0;
                r_pend  <= 1'b0;
            end else if (frame_start && (w_ferr_nxt || (w_pcnt_nxt != '0))) begin
                r_pend <= 1'b1;
            end
        end
    end

`ifdef VGA_FETCH_STATS_EN
    logic [15:0] r_ucnt;
    logic [7:0]  r_rcnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ucnt <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_empty_pop && (r_ucnt != 16'hFFFF))
                r_ucnt <= r_ucnt + 16'd1;
            if (w_flush && (r_rcnt != 8'hFF))
                r_rcnt <= r_rcnt + 8'd1;
        end
    end

    assign underflow_cnt = r_ucnt;
    assign resync_cnt    = r_rcnt;
`endif

    assign wbm_cyc   = r_cyc;
    assign wbm_stb   = r_cyc;
    assign wbm_we    = 1'b0;
    assign wbm_sel   = 4'hF;
    assign wbm_adr   = r_adr;
    assign pix_rgb   = r_rgb;
    assign underflow = r_uflow;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// tb_vga_pixel_fetch
//   Bench for vga_pixel_fetch with HDISP=4, VDISP=2, FIFO_DEPTH=8,
//   BASE_ADDR=0x100. A queue-based reference model tracks what the fetcher
//   must hold and emit; one process compares every cycle, and directed
//   scenarios pin the model with hand-computed literals.
// ----------------------------------------------------------------------------
module tb_vga_pixel_fetch;

    localparam int unsigned HD    = 4;
    localparam int unsigned VD    = 2;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h100;
    localparam int unsigned TOTAL = HD * VD;
    localparam logic [31:0] LAST  = BASE + 32'(4 * (TOTAL - 1));

    logic        clk;
    logic        rst;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack;
    logic        frame_start;
    logic        pix_req;
    logic [23:0] pix_rgb;
    logic        underflow;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0] underflow_cnt;
    logic [7:0]  resync_cnt;
`endif

    vga_pixel_fetch #(
        .HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(clk), .RST(rst),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we),
        .wbm_sel(wbm_sel), .wbm_adr(wbm_adr), .wbm_dat_i(wbm_dat_i),
        .wbm_ack(wbm_ack), .frame_start(frame_start), .pix_req(pix_req),
        .pix_rgb(pix_rgb), .underflow(underflow)
`ifdef VGA_FETCH_STATS_EN
        , .underflow_cnt(underflow_cnt), .resync_cnt(resync_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] q[$];
    logic [31:0] ack_log[$];
    logic [23:0] dat_log[$];
    logic [31:0] m_adr;
    logic        m_cyc, m_uflow, m_ferr, m_pend;
    logic [23:0] m_rgb;
    int          m_pcnt;
    bit          started = 0;

    task automatic model_step();
        int sz;
        bit flush;
        if (rst) begin
            q.delete();
            m_adr = BASE; m_cyc = 0; m_rgb = '0; m_uflow = 0;
            m_ferr = 0; m_pend = 0; m_pcnt = 0;
        end else begin
            sz = q.size();
            m_rgb = '0;
            if (pix_req) begin
                if (sz > 0) m_rgb = q.pop_front();
                else begin m_uflow = 1; m_ferr = 1; end
                m_pcnt = (m_pcnt + 1) % TOTAL;
            end
            flush = !m_cyc && m_pend;
            if (m_cyc) begin
                if (wbm_ack) begin
                    ack_log.push_back(wbm_adr);
                    dat_log.push_back(wbm_dat_i[23:0]);
                    if (!m_pend) begin
                        q.push_back(wbm_dat_i[23:0]);
                        m_adr = (m_adr == LAST) ? BASE : m_adr + 4;
                    end
                    m_cyc = 0;
                end
            end else begin
                m_cyc = !m_pend && (sz < DEPTH);
            end
            if (flush) begin
                q.delete();
                m_adr = BASE; m_pcnt = 0; m_ferr = 0; m_pend = 0;
            end else if (frame_start && (m_ferr || m_pcnt != 0)) begin
                m_pend = 1;
            end
        end
        started = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("cyc", {31'b0, wbm_cyc}, {31'b0, m_cyc});
            chk("stb", {31'b0, wbm_stb}, {31'b0, m_cyc});
            chk("adr", wbm_adr, m_adr);
            chk("rgb", {8'b0, pix_rgb}, {8'b0, m_rgb});
            chk("uflow", {31'b0, underflow}, {31'b0, m_uflow});
            chk("we_sel", {27'b0, wbm_we, wbm_sel}, 32'h0000000F);
        end
    end

    // ---------------- stimulus ----------------
    bit          ack_en = 0;
    logic [15:0] tag = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        wbm_ack = ack_en && wbm_cyc;
        tag = tag + 16'd1;
        wbm_dat_i = {8'h5A, wbm_adr[7:0], tag};
    endtask

    initial begin
        rst = 1; wbm_ack = 0; wbm_dat_i = '0; frame_start = 0; pix_req = 0;

        // 1: reset
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cyc", {31'b0, wbm_cyc}, 32'd0);
            chk("rst_adr", wbm_adr, 32'h100);
            chk("rst_rgb", {8'b0, pix_rgb}, 32'd0);
            chk("rst_uflow", {31'b0, underflow}, 32'd0);
        end
        rst = 0;
        chk("post_rst_cyc0", {31'b0, wbm_cyc}, 32'd0);
        tick();
        chk("post_rst_cyc1", {31'b0, wbm_cyc}, 32'd1);

        // 2: prefill to full with no pops
        ack_en = 1;
        repeat (24) tick();
        chk("t2_acks", ack_log.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("t2_adr_seq", ack_log[i], 32'h100 + 32'(4 * i));
        chk("t2_full_idle", {31'b0, wbm_cyc}, 32'd0);
        chk("t2_adr_wrap", wbm_adr, 32'h100);

        // 3: drain 8 in order, latency 1
        pix_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_rgb", {8'b0, pix_rgb}, {8'b0, dat_log[i]});
        end
        pix_req = 0;
        tick();
        chk("t3_rgb_idle", {8'b0, pix_rgb}, 32'd0);
        // aligned frame_start: no flush
        frame_start = 1; tick(); frame_start = 0;
        repeat (20) tick();
        chk("t3_acks", ack_log.size(), 32'd16);
        chk("t3_full_idle", {31'b0, wbm_cyc}, 32'd0);
        chk("t3_adr_wrap", wbm_adr, 32'h100);

        // 6: push and pop in the same cycle
        pix_req = 1; tick();
        chk("t6_rgb0", {8'b0, pix_rgb}, {8'b0, dat_log[8]});
        pix_req = 0; tick();
        pix_req = 1; tick();
        chk("t6_rgb1", {8'b0, pix_rgb}, {8'b0, dat_log[9]});
        pix_req = 0;
        repeat (4) tick();
        chk("t6_full_idle", {31'b0, wbm_cyc}, 32'd0);
        chk("t6_acks", ack_log.size(), 32'd18);
        ack_en = 0;
        pix_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_order", {8'b0, pix_rgb}, {8'b0, dat_log[10 + i]});
        end

        // 4: underflow, then resync with outstanding read discarded
        tick();
        chk("t4_rgb_empty", {8'b0, pix_rgb}, 32'd0);
        chk("t4_uflow", {31'b0, underflow}, 32'd1);
        pix_req = 0;
        frame_start = 1; tick(); frame_start = 0;
        wbm_ack = 1; tick();
        chk("t4_disc_cnt", ack_log.size(), 32'd19);
        chk("t4_disc_adr", ack_log[18], 32'h108);
        tick(); tick();
        chk("t4_resync_cyc", {31'b0, wbm_cyc}, 32'd1);
        chk("t4_resync_adr", wbm_adr, 32'h100);
        ack_en = 1;
        repeat (20) tick();
        chk("t4_refill", ack_log.size(), 32'd27);
        for (int i = 0; i < 8; i++)
            chk("t4_adr_seq", ack_log[19 + i], 32'h100 + 32'(4 * i));
        chk("t4_full_idle", {31'b0, wbm_cyc}, 32'd0);

        // 5a: exactly one frame consumed, frame_start has no effect
        pix_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5a_rgb", {8'b0, pix_rgb}, {8'b0, dat_log[19 + i]});
        end
        pix_req = 0;
        frame_start = 1; tick(); frame_start = 0;
        repeat (20) tick();
        chk("t5a_acks", ack_log.size(), 32'd35);
        chk("t5a_full_idle", {31'b0, wbm_cyc}, 32'd0);

        // 5b: short frame (5 pixels) forces a flush
        ack_en = 0;
        pix_req = 1; repeat (5) tick(); pix_req = 0;
        wbm_ack = 1; tick();
        chk("t5b_push_adr", ack_log[35], 32'h100);
        tick();
        chk("t5b_adr_step", wbm_adr, 32'h104);
        frame_start = 1; tick(); frame_start = 0;
        wbm_ack = 1; tick();
        chk("t5b_disc_adr", ack_log[36], 32'h104);
        tick(); tick();
        chk("t5b_resync_cyc", {31'b0, wbm_cyc}, 32'd1);
        chk("t5b_resync_adr", wbm_adr, 32'h100);
        pix_req = 1; tick(); pix_req = 0;
        chk("t5b_flushed_rgb", {8'b0, pix_rgb}, 32'd0);
        chk("t5b_uflow_sticky", {31'b0, underflow}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
